// File: rtl/muldiv_defs.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes, FSM state encoding and the iteration count.
package muldiv_defs;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  localparam int unsigned WIDTH_DEF = 32;

  // Value loaded into the step counter: one RUN cycle per operand bit.
  function automatic int unsigned iter_last(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath: a shift-add step
// (LSB-first multiply) or a restoring shift-subtract step (MSB-first divide).
module muldiv_step
  import muldiv_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               bit_in,
  input  op_e                mode,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic             div_mode;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;

  always_comb begin
    div_mode = (mode == OP_DIVU) || (mode == OP_DIV);

    // Multiply: {carry, upper + multiplicand} shifts right into the low half.
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, operand} : '0);

    // Divide: upper half is the partial remainder, lower half collects quotient
    // bits. The difference fits WIDTH bits whenever the subtraction is taken.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], bit_in};
    rem_diff = rem_sh[WIDTH-1:0] - operand;

    acc_nxt  = {add_sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      if (rem_sh >= {1'b0, operand}) begin
        acc_nxt = {rem_diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO
// registers; stalls HI/LO reads while an operation is in flight.
module muldiv_seq
  import muldiv_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             stall
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  op_e                op_q;
  logic               sign_q, sign_r;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   shf_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_nxt;
  logic               step_bit;

  logic               is_signed, is_div;
  logic [WIDTH-1:0]   res_hi, res_lo;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_sgn);
    return (is_sgn && (v < 0)) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] fix_word(input logic signed [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [ACC_W-1:0] fix_prod(input logic signed [ACC_W-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  // Multiply consumes multiplier bits LSB-first, divide consumes dividend bits MSB-first.
  assign step_bit = op_q[1] ? shf_q[WIDTH-1] : shf_q[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc_q),
    .operand (opnd_q),
    .bit_in  (step_bit),
    .mode    (op_q),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PREP;
      ST_PREP: state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign fix and HI/LO mapping applied on the way out of FIX.
  always_comb begin
    is_signed = op_q[0];
    is_div    = op_q[1];
    if (is_div) begin
      res_lo = fix_word(acc_q[WIDTH-1:0], is_signed & sign_q);
      res_hi = fix_word(acc_q[ACC_W-1:WIDTH], is_signed & sign_r);
    end else begin
      {res_hi, res_lo} = fix_prod(acc_q, is_signed & sign_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FIX);
      case (state_q)
        ST_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
        end
        ST_PREP: begin
          cnt_q <= CNT_W'(iter_last(WIDTH));
          dbz_q <= op[1] & (b == '0);
        end
        ST_RUN: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; PREP initialises them before use.
  always_ff @(posedge clk) begin
    if (state_q == ST_PREP) begin
      op_q   <= op_e'(op);
      sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
      sign_r <= a[WIDTH-1];
      acc_q  <= '0;
      if (op[1]) begin
        opnd_q <= mag(b, op[0]);
        shf_q  <= mag(a, op[0]);
      end else begin
        opnd_q <= mag(a, op[0]);
        shf_q  <= mag(b, op[0]);
      end
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_nxt;
      shf_q <= op_q[1] ? {shf_q[WIDTH-2:0], 1'b0} : {1'b0, shf_q[WIDTH-1:1]};
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign dbz   = dbz_q;
  assign stall = rd_req & busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_req = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, dbz, stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .rd_req(rd_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dbz(dbz), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic and C-style truncating division.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] p;
    e.k   = 0;
    e.dbz = o[1] && (y == 0);
    if (!o[1]) begin
      if (o[0]) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
      end else begin
        p = {32'b0, x} * {32'b0, y};
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 0) begin
      e.hi = x;
      e.lo = (o[0] && x[31]) ? 32'h1 : 32'hFFFF_FFFF;
    end else if (o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
        chk("dbz", dbz, mon_e.dbz);
        chk("latency", cyc - mon_e.k, 34);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  // Issues one operation starting at the current (post-edge or negedge) point and
  // returns at the negedge of the done cycle. poke adds mid-operation probes.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke, input bit wr_hi, input logic [31:0] wd);
    exp_t e;
    int nbusy, nstall;
    logic [31:0] hi_before;
    e = model(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    rd_req = poke;
    hi_we = wr_hi; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0;
    hi_we = 1'b0;
    e.k = cyc;
    sb.push_back(e);
    if (wr_hi) chk("mthi_with_start", hi, wd);
    hi_before = hi;
    nbusy = 0;
    nstall = 0;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      nbusy++;
      if (stall) nstall++;
      if (i == 1) begin
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      end
      if (poke) begin
        if (i == 3) begin hi_we = 1'b1; wdata = ~hi_before; end
        if (i == 4) begin chk("mthi_busy_ignored", hi, hi_before); hi_we = 1'b0; end
        if (i == 5) begin start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; end
        if (i == 6) start = 1'b0;
      end
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", busy, 0);
    if (poke) begin
      chk("busy_cycles", nbusy, 34);
      chk("stall_cycles", nstall, 34);
      chk("stall_after", stall, 0);
    end
    rd_req = 1'b0;
  endtask

  initial begin
    logic [1:0] ro;
    logic [31:0] rx, ry;
    rd_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_stall", stall, 0);
    rd_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h5678);
    chk("mtlo_hi_kept", hi, 32'h1234);
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'h0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hCAFE_0001);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    run_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    chk("dbz_held", dbz, 1);

    // Reset in the middle of an operation.
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", busy, 0);

    run_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = $urandom_range(1, 16);
        2: rx = $urandom_range(0, 255);
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, rx, ry, 1'b0, 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
